lsl_seq_unit: RTL and testbench

- Multi-cycle left-shift/rotate unit for the ALU. It is the opposite-direction counterpart of the right-shift (RSR) datapath.
- Shifts one bit position per clock under a start/busy/done handshake.
- Produces the shifted result and an updated flag nibble in the ALU's [N, Z, C, V] order, so the control unit can use it in place of a barrel shifter.

---
 rtl/lsl_seq_unit.sv | 79 +++++++
 tb/tb_lsl_seq_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lsl_seq_unit.sv
// Multi-cycle left shift / rotate unit: shifts one bit per clock and
// produces the result plus an updated [N,Z,C,V] flag nibble.
module lsl_seq_unit #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [N-1:0]     in2,
    input  logic             mode,
    input  logic             s,
    input  logic [3:0]       flag_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       new_flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [N-1:0]     cnt;
    logic             mode_q;
    logic             s_q;
    logic [3:0]       flag_q;
    logic             carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sreg     <= '0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            s_q      <= 1'b0;
            flag_q   <= '0;
            carry    <= 1'b0;
            result   <= '0;
            new_flag <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg   <= in1;
                        cnt    <= in2;
                        mode_q <= mode;
                        s_q    <= s;
                        flag_q <= flag_in;
                        carry  <= flag_in[1];
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != '0) begin
                        // Rotate refills with the bit leaving the top; shift fills with zero.
                        sreg  <= {sreg[WIDTH-2:0], mode_q ? sreg[WIDTH-1] : 1'b0};
                        carry <= sreg[WIDTH-1];
                        cnt   <= cnt - 1'b1;
                    end else begin
                        result   <= sreg;
                        new_flag <= s_q ? {sreg[WIDTH-1], (sreg == '0), carry, flag_q[0]}
                                        : flag_q;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_lsl_seq_unit.sv
// Self-checking bench for lsl_seq_unit: directed cases with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_lsl_seq_unit;

    localparam int W  = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in1 = '0;
    logic [NB-1:0] in2 = '0;
    logic          mode = 1'b0;
    logic          s = 1'b0;
    logic [3:0]    flag_in = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [3:0]    new_flag;

    lsl_seq_unit #(.WIDTH(W), .N(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
        .mode(mode), .s(s), .flag_in(flag_in), .busy(busy), .done(done),
        .result(result), .new_flag(new_flag)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-word arithmetic view of the operation: {result, flags}.
    function automatic logic [W+3:0] model_op(input logic [W-1:0] a, input int unsigned amt,
                                              input logic m, input logic sv, input logic [3:0] f);
        logic [W-1:0] r;
        logic         c;
        int unsigned  k;
        k = amt % W;
        if (m) r = (k == 0) ? a : ((a << k) | (a >> (W - k)));
        else   r = a << amt;
        if (amt == 0) c = f[1];
        else if (m)   c = r[0];
        else          c = a[W - amt];
        model_op = {r, (sv ? {r[W-1], (r == '0), c, f[0]} : f)};
    endfunction

    // Model: one outstanding operation, timeline measured in edges since acceptance.
    int unsigned  cyc = 0;
    bit           m_active = 1'b0;
    int unsigned  m_acc = 0;
    int unsigned  m_amt = 0;
    logic [W-1:0] m_res = '0;
    logic [3:0]   m_flag = '0;
    logic [W-1:0] p_res = '0;
    logic [3:0]   p_flag = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_res    = '0;
            m_flag   = '0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc - m_acc == m_amt + 1) begin
                    m_res  = p_res;
                    m_flag = p_flag;
                end else if (cyc - m_acc == m_amt + 2) begin
                    m_active = 1'b0;
                end
            end else if (start) begin
                m_active = 1'b1;
                m_acc    = cyc;
                m_amt    = in2;
                {p_res, p_flag} = model_op(in1, in2, mode, s, flag_in);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, (m_active && (cyc - m_acc <= m_amt)) ? 1 : 0);
            check("done", done, (m_active && (cyc - m_acc == m_amt + 1)) ? 1 : 0);
            check("result", result, m_res);
            check("new_flag", new_flag, m_flag);
        end
    end

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (m_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", m_active, 0);
    endtask

    // Runs one operation from IDLE; poke >= 0 pulses start with fresh operands at that edge offset.
    task automatic run_op(input logic [W-1:0] a, input logic [NB-1:0] b, input logic m,
                          input logic sv, input logic [3:0] f, input logic [W-1:0] er,
                          input logic [3:0] ef, input int poke, input string tag);
        int  j;
        int  bc;
        bit  seen;
        @(negedge clk);
        in1 = a; in2 = b; mode = m; s = sv; flag_in = f; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in1 = $urandom; in2 = NB'($urandom); mode = ~m; s = ~sv; flag_in = ~f;
        j = 0; bc = 0; seen = 1'b0;
        while (j < 40) begin
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            j++;
            @(negedge clk);
            start = (j == poke);
        end
        start = 1'b0;
        check({tag, "_latency"}, seen ? j : 999, int'(b) + 1);
        check({tag, "_busy_cycles"}, bc, int'(b) + 1);
        check({tag, "_result"}, result, er);
        check({tag, "_flag"}, new_flag, ef);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_flag", new_flag, 0);

        run_op(32'd3, 4'd1, 1'b0, 1'b1, 4'b0000, 32'd6, 4'b0000, -1, "t1");
        run_op(32'h80000001, 4'd1, 1'b0, 1'b1, 4'b0000, 32'h2, 4'b0010, -1, "t2");
        run_op(32'hFFFFFFFF, 4'd9, 1'b1, 1'b1, 4'b0000, 32'hFFFFFFFF, 4'b1010, -1, "t3rot");
        run_op(32'hFFFFFFFF, 4'd9, 1'b0, 1'b1, 4'b0000, 32'hFFFFFE00, 4'b1010, -1, "t3lsl");
        run_op(32'd0, 4'd0, 1'b0, 1'b1, 4'b1111, 32'd0, 4'b0111, -1, "t4");
        run_op(32'd16, 4'd2, 1'b0, 1'b0, 4'b0101, 32'd64, 4'b0101, 1, "t5");
        repeat (3) @(negedge clk);
        check("t5_held", result, 64);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        in1 = 32'd10; in2 = 4'd10; mode = 1'b0; s = 1'b1; flag_in = 4'b0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_result", result, 0);
        check("t6_flag", new_flag, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
        end
        run_op(32'd1, 4'd2, 1'b0, 1'b1, 4'b0000, 32'd4, 4'b0000, -1, "t6b");
        wait_idle();

        // Random traffic, including starts while busy or in DONE.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 2) == 0);
            in1     = $urandom;
            if ($urandom_range(0, 7) == 0) in1 = '0;
            in2     = NB'($urandom);
            mode    = 1'($urandom);
            s       = 1'($urandom);
            flag_in = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
